// File: rtl/scan_mux.sv
// N-channel, W-bit registered multiplexer with a manual select mode and an
// auto-scan mode that dwells DWELL enabled cycles on each channel.

module scan_mux_lane #(
    parameter int W = 1
) (
    input  logic         hit,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);
    always_comb begin
        dout = hit ? din : '0;
    end
endmodule

module scan_mux #(
    parameter int N     = 4,
    parameter int W     = 1,
    parameter int SEL_W = 2,
    parameter int DWELL = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             mode,
    input  logic [SEL_W-1:0] sel,
    input  logic [N*W-1:0]   din,
    output logic [W-1:0]     dout,
    output logic [SEL_W-1:0] ch,
    output logic             valid,
    output logic             wrap
);
    localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;

    logic [W-1:0]     dout_q, dout_d;
    logic [SEL_W-1:0] ch_q, ch_d;
    logic             valid_q, valid_d;
    logic             wrap_q, wrap_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [SEL_W-1:0]      mux_sel;
    logic                  sel_legal;
    logic [N-1:0]          hit;
    logic [N-1:0][W-1:0]   lane_dout;
    logic [W-1:0]          pick_data;

    // In SCAN the registered channel drives the mux, so dout and the step
    // decision both see the same (old) channel on a step edge.
    always_comb begin
        mux_sel   = mode ? ch_q : sel;
        sel_legal = (int'(sel) < N);
    end

    // One-hot AND-OR mux: an out-of-range select hits no lane and yields 0.
    for (genvar i = 0; i < N; i++) begin : g_lane
        always_comb begin
            hit[i] = (mux_sel == SEL_W'(i));
        end
        scan_mux_lane #(.W(W)) u_lane (
            .hit  (hit[i]),
            .din  (din[i*W +: W]),
            .dout (lane_dout[i])
        );
    end

    always_comb begin
        pick_data = '0;
        for (int i = 0; i < N; i++) begin
            pick_data = pick_data | lane_dout[i];
        end
    end

    always_comb begin
        dout_d  = dout_q;
        ch_d    = ch_q;
        valid_d = valid_q;
        wrap_d  = 1'b0;
        cnt_d   = cnt_q;
        if (en) begin
            dout_d = pick_data;
            if (!mode) begin
                cnt_d   = '0;
                valid_d = sel_legal;
                if (sel_legal) begin
                    ch_d = sel;
                end
            end else begin
                valid_d = 1'b1;
                if (cnt_q == CNT_W'(DWELL - 1)) begin
                    cnt_d = '0;
                    if (ch_q == SEL_W'(N - 1)) begin
                        ch_d   = '0;
                        wrap_d = 1'b1;
                    end else begin
                        ch_d = ch_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dout_q  <= '0;
            ch_q    <= '0;
            valid_q <= 1'b0;
            wrap_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            dout_q  <= dout_d;
            ch_q    <= ch_d;
            valid_q <= valid_d;
            wrap_q  <= wrap_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        dout  = dout_q;
        ch    = ch_q;
        valid = valid_q;
        wrap  = wrap_q;
    end
endmodule

// File: tb/tb_scan_mux.sv
// Bench for scan_mux: three configurations share one stimulus stream and are
// checked every cycle against an arithmetic scan-position model.

module tb_scan_mux;
    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, en, mode;
    logic [2:0]  sel;
    logic [31:0] din_all;

    logic [7:0] dout_o[3];
    logic [2:0] ch_o[3];
    logic       valid_o[3], wrap_o[3];
    logic [7:0] mdout_o[3];
    logic [2:0] mch_o[3];
    logic       mvalid_o[3], mwrap_o[3];

    int errors = 0;
    int checks = 0;

    // cfg0: N=4 W=8 DWELL=3; cfg1: N=3 W=4 DWELL=2; cfg2: N=5 W=2 SEL_W=3 DWELL=1
    for (genvar g = 0; g < 3; g++) begin : g_cfg
        localparam int NG = (g == 0) ? 4 : (g == 1) ? 3 : 5;
        localparam int WG = (g == 0) ? 8 : (g == 1) ? 4 : 2;
        localparam int SW = (g == 2) ? 3 : 2;
        localparam int DG = (g == 0) ? 3 : (g == 1) ? 2 : 1;

        logic [WG-1:0] dout;
        logic [SW-1:0] ch;
        logic          valid, wrap;

        scan_mux #(.N(NG), .W(WG), .SEL_W(SW), .DWELL(DG)) u_dut (
            .clk   (clk),
            .rst   (rst),
            .en    (en),
            .mode  (mode),
            .sel   (sel[SW-1:0]),
            .din   (din_all[NG*WG-1:0]),
            .dout  (dout),
            .ch    (ch),
            .valid (valid),
            .wrap  (wrap)
        );

        assign dout_o[g]  = 8'(dout);
        assign ch_o[g]    = 3'(ch);
        assign valid_o[g] = valid;
        assign wrap_o[g]  = wrap;

        // Scan position = base + (enabled scan cycles since start) / DWELL, mod N.
        int         base = 0, steps = 0, m_ch = 0;
        logic [7:0] m_dout = '0;
        logic       m_valid = 1'b0, m_wrap = 1'b0;

        always @(posedge clk) begin
            int c, sl, nsteps;
            sl = int'(sel[SW-1:0]);
            c  = (base + steps / DG) % NG;
            if (rst) begin
                base <= 0; steps <= 0; m_ch <= 0;
                m_dout <= '0; m_valid <= 1'b0; m_wrap <= 1'b0;
            end else if (!en) begin
                m_wrap <= 1'b0;
            end else if (!mode) begin
                m_wrap <= 1'b0;
                steps  <= 0;
                if (sl < NG) begin
                    base <= sl; m_ch <= sl; m_valid <= 1'b1;
                    m_dout <= 8'(din_all[sl*WG +: WG]);
                end else begin
                    base <= m_ch; m_dout <= '0; m_valid <= 1'b0;
                end
            end else begin
                nsteps = steps + 1;
                steps   <= nsteps;
                m_dout  <= 8'(din_all[c*WG +: WG]);
                m_valid <= 1'b1;
                m_ch    <= (base + nsteps / DG) % NG;
                m_wrap  <= ((nsteps % DG) == 0) && (c == NG - 1);
            end
        end

        assign mdout_o[g]  = m_dout;
        assign mch_o[g]    = 3'(m_ch);
        assign mvalid_o[g] = m_valid;
        assign mwrap_o[g]  = m_wrap;
    end

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Advance one clock, then compare every configuration against the model.
    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
        for (int g = 0; g < 3; g++) begin
            cmp($sformatf("model cfg%0d dout", g),  32'(dout_o[g]),  32'(mdout_o[g]));
            cmp($sformatf("model cfg%0d ch", g),    32'(ch_o[g]),    32'(mch_o[g]));
            cmp($sformatf("model cfg%0d valid", g), 32'(valid_o[g]), 32'(mvalid_o[g]));
            cmp($sformatf("model cfg%0d wrap", g),  32'(wrap_o[g]),  32'(mwrap_o[g]));
        end
    endtask

    logic [7:0] exp_t2[4] = '{8'hA0, 8'hB1, 8'hC2, 8'hD3};
    int         exp_t4[12] = '{0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3, 0};

    initial begin
        rst = 1'b1; en = 1'b1; mode = 1'b0; sel = '0; din_all = $urandom;

        // T1 reset
        cyc();
        din_all = $urandom;
        mode = 1'b1;
        cyc();
        for (int g = 0; g < 3; g++) begin
            cmp($sformatf("T1 cfg%0d dout", g),  32'(dout_o[g]),  0);
            cmp($sformatf("T1 cfg%0d ch", g),    32'(ch_o[g]),    0);
            cmp($sformatf("T1 cfg%0d valid", g), 32'(valid_o[g]), 0);
            cmp($sformatf("T1 cfg%0d wrap", g),  32'(wrap_o[g]),  0);
        end

        // T2 manual sweep on cfg0
        rst = 1'b0; mode = 1'b0; din_all = 32'hD3C2B1A0;
        for (int i = 0; i < 4; i++) begin
            sel = 3'(i);
            cyc();
            cmp("T2 dout", 32'(dout_o[0]), 32'(exp_t2[i]));
            cmp("T2 ch", 32'(ch_o[0]), 32'(i));
            cmp("T2 valid", 32'(valid_o[0]), 1);
        end

        // T3 illegal select on cfg1 (N=3)
        sel = 3'd1; cyc();
        sel = 3'd3; cyc();
        cmp("T3 illegal dout", 32'(dout_o[1]), 0);
        cmp("T3 illegal valid", 32'(valid_o[1]), 0);
        cmp("T3 illegal ch held", 32'(ch_o[1]), 1);
        sel = 3'd1; cyc();
        cmp("T3 legal valid", 32'(valid_o[1]), 1);
        cmp("T3 legal dout", 32'(dout_o[1]), 32'h0A);

        // T4 scan DWELL=3 on cfg0
        rst = 1'b1; cyc();
        rst = 1'b0; mode = 1'b1;
        for (int i = 0; i < 12; i++) begin
            din_all = $urandom;
            cyc();
            cmp($sformatf("T4 ch step%0d", i + 1), 32'(ch_o[0]), 32'(exp_t4[i]));
            cmp($sformatf("T4 wrap step%0d", i + 1), 32'(wrap_o[0]), 32'(i == 11));
        end

        // T5 enable gating mid-dwell on cfg1 (DWELL=2)
        rst = 1'b1; cyc();
        rst = 1'b0; din_all = 32'h0000_0005;
        cyc();
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            din_all = $urandom;
            cyc();
            cmp("T5 frozen ch", 32'(ch_o[1]), 0);
            cmp("T5 frozen dout", 32'(dout_o[1]), 32'h5);
            cmp("T5 frozen wrap", 32'(wrap_o[1]), 0);
        end
        en = 1'b1; din_all = 32'h0000_0007;
        cyc();
        cmp("T5 deferred step ch", 32'(ch_o[1]), 1);
        cmp("T5 step dout", 32'(dout_o[1]), 32'h7);

        // T6 reset mid-scan on cfg2 (N=5, DWELL=1)
        rst = 1'b1; cyc();
        rst = 1'b0;
        cyc(); cyc();
        cmp("T6 pre-reset ch", 32'(ch_o[2]), 2);
        rst = 1'b1; cyc();
        cmp("T6 reset ch", 32'(ch_o[2]), 0);
        cmp("T6 reset valid", 32'(valid_o[2]), 0);
        rst = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            din_all = $urandom;
            cyc();
            cmp("T6 resume ch", 32'(ch_o[2]), 32'(i % 5));
            cmp("T6 resume wrap", 32'(wrap_o[2]), 32'(i == 5));
            cmp("T6 resume valid", 32'(valid_o[2]), 1);
        end

        // Randomised traffic with occasional reset and mode flips
        for (int i = 0; i < 4000; i++) begin
            rst     = ($urandom_range(0, 149) == 0);
            en      = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 19) == 0) mode = ~mode;
            sel     = 3'($urandom);
            din_all = $urandom;
            cyc();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
